sqrt_significand_unit: RTL and testbench
========================================

Name: sqrt_significand_unit

Overview:
- Sequential radix-2 restoring square-root engine for the IEEE-754 double-precision significand.
- Sits downstream of the sqrt exponent handler and consumes its two outputs: the already-halved biased exponent, and the odd-exponent flag that says the significand must be doubled.
- Produces a 52-bit result fraction, truncated toward zero, plus an inexact flag.
- Assembles the result exponent/fraction pair for the sqrt packer.

Parameters:
- FRAC_W, 52, stored fraction width (hidden bit excluded).
- EXP_W, 11, exponent width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when the unit is idle or done
- frac_in  input  FRAC_W  radicand fraction f; significand is 1.f
- exp_odd  input  1  1 = exponent was odd, significand doubled before the root
- exp_in  input  EXP_W  exponent from the exponent handler, already halved and rebiased
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse, result valid
- frac_out  output  FRAC_W  result fraction (hidden bit dropped)
- exp_out  output  EXP_W  copy of exp_in captured at start
- inexact  output  1  final remainder is nonzero

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, frac_out, exp_out and inexact all 0.
- Reset asserted mid-operation aborts the computation at the next edge. No done pulse is produced.
- Arithmetic:
  - M = {1, frac_in} shifted left by exp_odd (54-bit value).
  - Radicand X = M << 52 (106 bits).
  - Q = floor(sqrt(X)), always 53 bits with Q[52]=1. This holds for every input (range 2^52..2^53-1).
  - frac_out = Q[51:0]; inexact = (X - Q^2 != 0).
- Restoring recurrence, one result bit per cycle, MSB first:
  - Each iteration shifts the next 2 radicand bits into the partial remainder (at least 55 bits wide).
  - Trial = (remainder << 2 | next 2 bits) - (Q_partial << 2 | 1).
  - If trial >= 0: keep the trial as the new remainder and append 1. Otherwise keep the old remainder and append 0.
- FSM states and transitions:
  - IDLE:
    - busy=0, done=0.
    - start=1 -> latch frac_in, exp_odd, exp_in; clear remainder and Q; iteration counter=52; go to CALC.
  - CALC:
    - busy=1.
    - Each edge: one iteration, then counter decrements.
    - On the edge processing counter=0: write frac_out, exp_out and inexact; set done=1; busy=0; go to DONE.
  - DONE:
    - done=1 for exactly this one cycle.
    - start=1 -> accepted exactly as in IDLE, with done cleared. Back-to-back operations are allowed.
    - Otherwise go to IDLE.
- Latency: start sampled at edge N means busy is high from N+1 through N+53, and done is high in the cycle after edge N+53, i.e. 53 cycles from acceptance.
- start during CALC is ignored. In-flight inputs are unaffected by changes to frac_in, exp_odd or exp_in after acceptance.
- frac_out, exp_out and inexact hold their values until the next completion or reset. They are not cleared when a new start is accepted.
- exp_out is exactly exp_in as captured. No exponent arithmetic is done here, and no special-value (zero/inf/NaN/negative) handling is done here. Those are handled by the exponent handler and the packer.

Test Plan:
- Reset, then frac_in=0, exp_odd=0, start 1 cycle -> 53 cycles later done=1; frac_out=0x0000000000000, inexact=0; exp_out equals exp_in (e.g. 0x3FF).
- frac_in=0, exp_odd=1, exp_in=0x3FF -> frac_out=0x6A09E667F3BCC, inexact=1, exp_out=0x3FF.
- frac_in=0x2000000000000, exp_odd=1 (significand 2.25) -> frac_out=0x8000000000000, inexact=0.
- frac_in=0xFFFFFFFFFFFFF, exp_odd=1 -> frac_out=0xFFFFFFFFFFFFF, inexact=1.
- Start with the second case; assert start with other data at cycles 10 and 30; hold start high in the DONE cycle -> the first result is unchanged and arrives at the correct time; the DONE-cycle start is accepted and its result follows 53 cycles later; exactly two done pulses.
- Start, then assert rst at cycle 20 for 1 cycle -> next cycle busy=0, done=0, all outputs 0; no done pulse afterwards. A new start then completes normally.

Source files
------------

// File: rtl/sqrt_significand_unit.sv
// Sequential radix-2 restoring square root for the double-precision
// significand. One result bit per cycle, 53 iterations, truncated result.
module sqrt_significand_unit #(
    parameter int unsigned FRAC_W = 52,
    parameter int unsigned EXP_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic              exp_odd,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W-1:0] frac_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              inexact
);

    localparam int unsigned MW = FRAC_W + 2;      // doubled significand width
    localparam int unsigned XW = 2 * FRAC_W + 2;  // radicand width
    localparam int unsigned QW = FRAC_W + 1;      // root width
    localparam int unsigned RW = FRAC_W + 4;      // partial remainder width
    localparam int unsigned CW = $clog2(FRAC_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [XW-1:0]   x_sr;
    logic [RW-1:0]   rem;
    logic [QW-1:0]   q;
    logic [CW-1:0]   cnt;
    logic [EXP_W-1:0] exp_lat;

    logic            accept;
    logic [MW-1:0]   m;
    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   dvs;
    logic [RW:0]     trial;
    logic            q_bit;
    logic [RW-1:0]   rem_nx;
    logic [QW-1:0]   q_nx;

    // Next-state decode; a start is honoured in IDLE and in the DONE cycle.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CALC;
                    accept   = 1'b1;
                end
            end
            CALC: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nx = CALC;
                    accept   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // One restoring step: bring in the next radicand bit pair and try
    // subtracting 4*Q+1; a non-negative trial sets the next root bit.
    always_comb begin
        m      = exp_odd ? {1'b1, frac_in, 1'b0} : {1'b0, 1'b1, frac_in};
        rem_sh = (rem << 2) | RW'(x_sr[XW-1 -: 2]);
        dvs    = RW'({q, 2'b01});
        trial  = {1'b0, rem_sh} - {1'b0, dvs};
        q_bit  = ~trial[RW];
        rem_nx = q_bit ? trial[RW-1:0] : rem_sh;
        q_nx   = {q[QW-2:0], q_bit};
    end

    // State register, iteration datapath and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x_sr     <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            exp_lat  <= '0;
            frac_out <= '0;
            exp_out  <= '0;
            inexact  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                x_sr    <= {m, {FRAC_W{1'b0}}};
                rem     <= '0;
                q       <= '0;
                cnt     <= CW'(FRAC_W);
                exp_lat <= exp_in;
            end else if (state == CALC) begin
                x_sr <= x_sr << 2;
                rem  <= rem_nx;
                q    <= q_nx;
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    frac_out <= q_nx[FRAC_W-1:0];
                    exp_out  <= exp_lat;
                    inexact  <= (rem_nx != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_sqrt_significand_unit.sv
// Scoreboard bench for sqrt_significand_unit: the driver pushes expected
// results on acceptance, the monitor pops and compares on each done pulse.
module tb_sqrt_significand_unit;

    localparam int FRAC_W = 52;
    localparam int EXP_W  = 11;
    localparam int LAT    = 53;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [FRAC_W-1:0] frac_in;
    logic              exp_odd;
    logic [EXP_W-1:0]  exp_in;
    logic              busy, done, inexact;
    logic [FRAC_W-1:0] frac_out;
    logic [EXP_W-1:0]  exp_out;

    sqrt_significand_unit #(.FRAC_W(FRAC_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .frac_in(frac_in),
        .exp_odd(exp_odd), .exp_in(exp_in), .busy(busy), .done(done),
        .frac_out(frac_out), .exp_out(exp_out), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRAC_W-1:0] frac;
        logic [EXP_W-1:0]  expo;
        logic              inex;
        int                acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   asserts = 0;
    int   fails = 0;
    int   pulses = 0;
    int   want_pulses = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: largest Q in [2^52, 2^53) with Q*Q <= X, by binary search.
    function automatic exp_t model(input logic [FRAC_W-1:0] f, input logic odd,
                                   input logic [EXP_W-1:0] e);
        logic [127:0] x, lo, hi, mid;
        exp_t r;
        x  = {75'd0, 1'b1, f} << odd;
        x  = x << 52;
        lo = 128'd1 << 52;
        hi = (128'd1 << 53) - 1;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        r.frac    = lo[FRAC_W-1:0];
        r.expo    = e;
        r.inex    = (x - lo * lo) != 0;
        r.acc_cyc = 0;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            pulses++;
            if (prev_done) check("done_single_pulse", 64'd1, 64'd0);
            check("busy_low_at_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("frac_out", 64'(frac_out), 64'(e.frac));
                check("exp_out", 64'(exp_out), 64'(e.expo));
                check("inexact", {63'd0, inexact}, {63'd0, e.inex});
                check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
            end
        end
        prev_done <= done;
    end

    // Drive one accepted request (DUT must be idle or done) and queue its result.
    task automatic do_start(input logic [FRAC_W-1:0] f, input logic odd,
                            input logic [EXP_W-1:0] e, input exp_t r);
        exp_t rr;
        @(negedge clk);
        frac_in = f; exp_odd = odd; exp_in = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rr = r;
        rr.acc_cyc = cyc;
        sb.push_back(rr);
        want_pulses++;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            want_pulses -= sb.size();
            sb.delete();
        end
    endtask

    function automatic exp_t mk(input logic [FRAC_W-1:0] f, input logic [EXP_W-1:0] e,
                                input logic inex);
        exp_t r;
        r.frac = f; r.expo = e; r.inex = inex; r.acc_cyc = 0;
        return r;
    endfunction

    initial begin
        logic [FRAC_W-1:0] rf;
        logic              ro;
        logic [EXP_W-1:0]  re;
        int                a;

        rst = 1'b1; start = 1'b0; frac_in = '0; exp_odd = 1'b0; exp_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_frac", 64'(frac_out), 64'd0);
        check("reset_exp", 64'(exp_out), 64'd0);
        check("reset_inexact", {63'd0, inexact}, 64'd0);

        // Directed significands with known roots.
        do_start(52'h0, 1'b0, 11'h3FF, mk(52'h0, 11'h3FF, 1'b0));
        drain();
        do_start(52'h0, 1'b1, 11'h3FF, mk(52'h6A09E667F3BCC, 11'h3FF, 1'b1));
        drain();
        do_start(52'h2000000000000, 1'b1, 11'h200, mk(52'h8000000000000, 11'h200, 1'b0));
        drain();
        do_start(52'hFFFFFFFFFFFFF, 1'b1, 11'h7FE, mk(52'hFFFFFFFFFFFFF, 11'h7FE, 1'b1));
        drain();

        // Starts during CALC are ignored; a start in the DONE cycle is taken.
        do_start(52'h0, 1'b1, 11'h3FF, mk(52'h6A09E667F3BCC, 11'h3FF, 1'b1));
        a = cyc;
        while (cyc - a < 60) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc - a == 10 || cyc - a == 30) begin
                frac_in = 52'h123456789ABCD; exp_odd = 1'b0; exp_in = 11'h055;
                start = 1'b1;
            end else if (cyc - a == LAT) begin
                frac_in = 52'h2000000000000; exp_odd = 1'b1; exp_in = 11'h321;
                start = 1'b1;
                sb.push_back('{52'h8000000000000, 11'h321, 1'b0, a + LAT + 1});
                want_pulses++;
            end else if (cyc - a == LAT + 2) begin
                check("hold_frac_during_next", 64'(frac_out), 64'h6A09E667F3BCC);
                check("busy_after_back_to_back", {63'd0, busy}, 64'd1);
            end
        end
        start = 1'b0;
        drain();

        // Reset mid-computation aborts without a done pulse.
        do_start(52'hABCDE12345678, 1'b0, 11'h111, mk(52'h0, 11'h0, 1'b0));
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        want_pulses -= sb.size();
        sb.delete();
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_frac", 64'(frac_out), 64'd0);
        check("abort_exp", 64'(exp_out), 64'd0);
        check("abort_inexact", {63'd0, inexact}, 64'd0);
        repeat (70) @(negedge clk);
        do_start(52'h2000000000000, 1'b1, 11'h3FE, mk(52'h8000000000000, 11'h3FE, 1'b0));
        drain();

        // Randomized vectors against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf = {$urandom, $urandom} ;
            ro = 1'($urandom_range(0, 1));
            re = 11'($urandom);
            do_start(rf, ro, re, model(rf, ro, re));
            drain();
        end

        repeat (5) @(negedge clk);
        check("done_pulse_count", 64'(pulses), 64'(want_pulses));
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
